my_mod_ramp_gen_v1: RTL and testbench

- Drives the gyro phase modulator: a square-wave bias modulation plus a serrodyne phase ramp summed into one DAC word.
- Sources the modulation status/edge-trigger pair that the error-signal generator consumes.
- Advances the ramp by the loop step each time the error generator issues its ramp-sync pulse.
- Sits between the error generator / loop filter and the modulator DAC interface.

---
 rtl/my_mod_ramp_gen_v1_pkg.sv | 25 ++
 rtl/my_ramp_accum.sv | 59 +++++
 rtl/my_mod_ramp_gen_v1.sv | 148 ++++++++++++++
 tb/tb_my_mod_ramp_gen_v1.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/my_mod_ramp_gen_v1_pkg.sv
// ---------------------------------------------------------------------------
// my_mod_ramp_gen_v1_pkg
// Shared definitions for the gyro modulation / serrodyne ramp generator.
// The error-signal generator and its bench import the same state type so that
// o_cstate can be decoded identically on both sides.
//   mod_state_t  : modulation FSM state (IDLE / MOD_H / MOD_L)
//   MOD_MIN_HALF : smallest legal modulation half-period in clocks
//   clamp_half() : raises a requested half-period to a minimum value
// ---------------------------------------------------------------------------
package my_mod_ramp_gen_v1_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MOD_H = 2'd1,
    MOD_L = 2'd2
  } mod_state_t;

  localparam int MOD_MIN_HALF = 2;

  function automatic logic [31:0] clamp_half(input logic [31:0] hp,
                                             input logic [31:0] min_half);
    return (hp < min_half) ? min_half : hp;
  endfunction

endpackage

// File: rtl/my_ramp_accum.sv
// ---------------------------------------------------------------------------
// my_ramp_accum
// 32-bit serrodyne phase accumulator (full scale = 2*pi) with wrap detect.
//   clk   : system clock
//   rst   : asynchronous, active-high reset
//   en    : ramp enable; low clears the accumulator every cycle
//   sync  : one-cycle pulse; add step to the accumulator
//   step  : signed ramp increment
//   acc   : accumulator value
//   wrap  : one-cycle pulse, the cycle after an update that crossed 2*pi
// ---------------------------------------------------------------------------
module my_ramp_accum (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               sync,
  input  logic signed [31:0] step,
  output logic        [31:0] acc,
  output logic               wrap
);

  logic [31:0] acc_q, acc_d;
  logic        wrap_q, wrap_d;
  logic [31:0] acc_sum;

  // Natural modulo-2^32 add; the phase is treated as unsigned.
  assign acc_sum = acc_q + $unsigned(step);

  always_comb begin
    acc_d  = acc_q;
    wrap_d = 1'b0;
    if (!en) begin
      acc_d = '0;
    end else if (sync) begin
      acc_d = acc_sum;
      // A positive step wraps when the phase moves backwards, a negative
      // step when it moves forwards; a zero step never changes the phase.
      if ((step > 32'sd0) && (acc_sum < acc_q)) begin
        wrap_d = 1'b1;
      end else if ((step < 32'sd0) && (acc_sum > acc_q)) begin
        wrap_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      wrap_q <= wrap_d;
    end
  end

  assign acc  = acc_q;
  assign wrap = wrap_q;

endmodule

// File: rtl/my_mod_ramp_gen_v1.sv
// ---------------------------------------------------------------------------
// my_mod_ramp_gen_v1
// Square-wave bias modulation plus serrodyne phase ramp, summed into one
// DAC word for the gyro phase modulator.
//   i_clk, i_rst     : clock, asynchronous active-high reset
//   i_en             : modulation enable (level)
//   i_half_period    : modulation half-period in clocks (clamped to MIN_HALF)
//   i_mod_amp_h/_l   : signed offsets added during the high / low half
//   i_step           : signed ramp increment from the loop filter
//   i_ramp_sync      : one-cycle pulse, apply i_step
//   i_ramp_en        : ramp enable, low clears the accumulator
//   o_status, o_trig : modulation level and first-cycle-of-half pulse
//   o_mod_dac        : top DAC_BIT bits of (ramp + modulation offset)
//   o_ramp           : ramp accumulator (debug)
//   o_ramp_wrap      : accumulator wrapped (2*pi reset) pulse
//   o_cstate         : FSM state (debug)
// ---------------------------------------------------------------------------
module my_mod_ramp_gen_v1
  import my_mod_ramp_gen_v1_pkg::*;
#(
  parameter int DAC_BIT  = 16,
  parameter int MIN_HALF = MOD_MIN_HALF
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_en,
  input  logic        [31:0]        i_half_period,
  input  logic signed [31:0]        i_mod_amp_h,
  input  logic signed [31:0]        i_mod_amp_l,
  input  logic signed [31:0]        i_step,
  input  logic                      i_ramp_sync,
  input  logic                      i_ramp_en,
  output logic                      o_status,
  output logic                      o_trig,
  output logic signed [DAC_BIT-1:0] o_mod_dac,
  output logic        [31:0]        o_ramp,
  output logic                      o_ramp_wrap,
  output logic        [1:0]         o_cstate
);

  mod_state_t                state_q, state_d;
  logic        [31:0]        cnt_q, cnt_d;
  logic                      status_q, status_d;
  logic                      trig_q, trig_d;
  logic signed [DAC_BIT-1:0] dac_q, dac_d;

  logic [31:0] hp_m1;
  logic [31:0] acc;
  logic [31:0] dac_sum;
  logic        ramp_wrap;

  // Reload value for the half-period counter; i_half_period is sampled only
  // here, so a mid-half change takes effect at the next reload.
  assign hp_m1 = clamp_half(i_half_period, 32'(MIN_HALF)) - 32'd1;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    status_d = status_q;
    trig_d   = 1'b0;
    if (!i_en) begin
      // Disable never emits a trigger.
      state_d  = IDLE;
      cnt_d    = '0;
      status_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d  = MOD_H;
          status_d = 1'b1;
          trig_d   = 1'b1;
          cnt_d    = hp_m1;
        end
        MOD_H: begin
          if (cnt_q == '0) begin
            state_d  = MOD_L;
            status_d = 1'b0;
            trig_d   = 1'b1;
            cnt_d    = hp_m1;
          end else begin
            cnt_d = cnt_q - 32'd1;
          end
        end
        MOD_L: begin
          if (cnt_q == '0) begin
            state_d  = MOD_H;
            status_d = 1'b1;
            trig_d   = 1'b1;
            cnt_d    = hp_m1;
          end else begin
            cnt_d = cnt_q - 32'd1;
          end
        end
        default: begin
          state_d  = IDLE;
          cnt_d    = '0;
          status_d = 1'b0;
        end
      endcase
    end
  end

  // DAC word uses the registered acc and status, hence it lags them by one
  // cycle. The shift keeps only the top DAC_BIT bits of the 32-bit sum.
  assign dac_sum = acc + $unsigned(status_q ? i_mod_amp_h : i_mod_amp_l);

  always_comb begin
    dac_d = '0;
    if (state_q != IDLE) begin
      dac_d = DAC_BIT'(dac_sum >> (32 - DAC_BIT));
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      status_q <= 1'b0;
      trig_q   <= 1'b0;
      dac_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      status_q <= status_d;
      trig_q   <= trig_d;
      dac_q    <= dac_d;
    end
  end

  // The ramp only advances while modulation is enabled.
  my_ramp_accum u_ramp_accum (
    .clk  (i_clk),
    .rst  (i_rst),
    .en   (i_ramp_en),
    .sync (i_ramp_sync & i_en),
    .step (i_step),
    .acc  (acc),
    .wrap (ramp_wrap)
  );

  assign o_status    = status_q;
  assign o_trig      = trig_q;
  assign o_mod_dac   = dac_q;
  assign o_ramp      = acc;
  assign o_ramp_wrap = ramp_wrap;
  assign o_cstate    = state_q;

endmodule

// File: tb/tb_my_mod_ramp_gen_v1.sv
module tb_my_mod_ramp_gen_v1;

  logic               i_clk;
  logic               i_rst;
  logic               i_en;
  logic        [31:0] i_half_period;
  logic signed [31:0] i_mod_amp_h;
  logic signed [31:0] i_mod_amp_l;
  logic signed [31:0] i_step;
  logic               i_ramp_sync;
  logic               i_ramp_en;
  logic               o_status;
  logic               o_trig;
  logic signed [15:0] o_mod_dac;
  logic        [31:0] o_ramp;
  logic               o_ramp_wrap;
  logic        [1:0]  o_cstate;

  int total = 0;
  int bad   = 0;

  // Reference model: tracks whether modulation runs, the current level,
  // how many cycles of the current half have been shown and its length.
  bit          m_on, m_level, m_trig, m_wrap;
  int unsigned m_pos, m_len;
  logic [31:0] m_acc;
  logic [15:0] m_dac;

  my_mod_ramp_gen_v1 #(.DAC_BIT(16), .MIN_HALF(2)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_en         (i_en),
    .i_half_period(i_half_period),
    .i_mod_amp_h  (i_mod_amp_h),
    .i_mod_amp_l  (i_mod_amp_l),
    .i_step       (i_step),
    .i_ramp_sync  (i_ramp_sync),
    .i_ramp_en    (i_ramp_en),
    .o_status     (o_status),
    .o_trig       (o_trig),
    .o_mod_dac    (o_mod_dac),
    .o_ramp       (o_ramp),
    .o_ramp_wrap  (o_ramp_wrap),
    .o_cstate     (o_cstate)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_on = 0; m_level = 0; m_trig = 0; m_wrap = 0;
    m_pos = 0; m_len = 0; m_acc = '0; m_dac = '0;
  endtask

  function automatic int unsigned half_len(input logic [31:0] hp);
    return (hp < 2) ? 2 : hp;
  endfunction

  // One clock edge of the behavioural model, from the inputs held across it.
  task automatic model_step();
    logic [31:0] sum;
    logic [31:0] nacc;
    if (i_rst) begin
      model_reset();
      return;
    end
    sum   = m_acc + (m_level ? i_mod_amp_h : i_mod_amp_l);
    m_dac = m_on ? sum[31:16] : 16'h0;
    m_wrap = 0;
    if (!i_ramp_en) begin
      m_acc = '0;
    end else if (i_ramp_sync && i_en) begin
      nacc = m_acc + i_step;
      if (i_step > 0)      m_wrap = (nacc < m_acc);
      else if (i_step < 0) m_wrap = (nacc > m_acc);
      m_acc = nacc;
    end
    if (!i_en) begin
      m_on = 0; m_level = 0; m_trig = 0;
    end else if (!m_on) begin
      m_on = 1; m_level = 1; m_trig = 1; m_pos = 1; m_len = half_len(i_half_period);
    end else if (m_pos == m_len) begin
      m_level = !m_level; m_trig = 1; m_pos = 1; m_len = half_len(i_half_period);
    end else begin
      m_pos++; m_trig = 0;
    end
  endtask

  task automatic check_all();
    chk("status", {31'd0, o_status}, {31'd0, m_level});
    chk("trig", {31'd0, o_trig}, {31'd0, m_trig});
    chk("dac", {16'd0, o_mod_dac}, {16'd0, m_dac});
    chk("ramp", o_ramp, m_acc);
    chk("wrap", {31'd0, o_ramp_wrap}, {31'd0, m_wrap});
    chk("cstate", {30'd0, o_cstate}, !m_on ? 32'd0 : (m_level ? 32'd1 : 32'd2));
  endtask

  task automatic tick();
    @(posedge i_clk);
    model_step();
    @(negedge i_clk);
    check_all();
  endtask

  initial begin
    bit prev_level;
    i_rst = 1; i_en = 0; i_half_period = 5;
    i_mod_amp_h = 0; i_mod_amp_l = 0; i_step = 0;
    i_ramp_sync = 0; i_ramp_en = 0;
    model_reset();
    tick(); tick();
    i_rst = 0;
    tick();

    // Basic modulation, half-period 5
    i_en = 1;
    tick();
    chk("first_trig", {31'd0, o_trig}, 32'd1);
    chk("first_status", {31'd0, o_status}, 32'd1);
    repeat (24) tick();

    // Clamp of 0 and 1, then a mid-half change to 8
    i_half_period = 0; repeat (10) tick();
    i_half_period = 1; repeat (9) tick();
    i_half_period = 8; repeat (30) tick();

    // Ramp and wrap
    i_ramp_en = 1; i_step = 32'hFFFF_FFF0; i_ramp_sync = 1; tick();
    chk("acc_preset", o_ramp, 32'hFFFF_FFF0);
    i_step = 32'h20; tick();
    i_ramp_sync = 0; tick();
    chk("acc_wrap_up", o_ramp, 32'h0000_0010);
    chk("wrap_up", {31'd0, o_ramp_wrap}, 32'd0);
    i_step = -32'sh20; i_ramp_sync = 1; tick();
    chk("acc_wrap_dn", o_ramp, 32'hFFFF_FFF0);
    chk("wrap_dn", {31'd0, o_ramp_wrap}, 32'd1);
    i_ramp_sync = 0; tick();

    // DAC sum with acc=0x1000_0000
    i_ramp_en = 0; tick();
    i_ramp_en = 1; i_step = 32'h1000_0000; i_ramp_sync = 1; tick();
    i_ramp_sync = 0; i_half_period = 5;
    i_mod_amp_h = 32'h0100_0000; i_mod_amp_l = 32'hFF00_0000;
    tick();
    repeat (20) begin
      prev_level = m_level;
      tick();
      chk("dac_alt", {16'd0, o_mod_dac}, prev_level ? 32'h1100 : 32'h0F00);
    end

    // Disable mid-MOD_H
    i_en = 0; tick();
    i_en = 1; tick(); tick(); tick();
    i_en = 0; tick();
    chk("dis_state", {30'd0, o_cstate}, 32'd0);
    chk("dis_status", {31'd0, o_status}, 32'd0);
    chk("dis_trig", {31'd0, o_trig}, 32'd0);
    tick();
    chk("dis_dac", {16'd0, o_mod_dac}, 32'd0);
    i_ramp_en = 0; tick();
    chk("dis_acc", o_ramp, 32'd0);

    // Randomized operation
    for (int n = 0; n < 400; n++) begin
      i_en          = ($urandom % 16) != 0;
      i_ramp_en     = ($urandom % 24) != 0;
      i_ramp_sync   = ($urandom % 4) == 0;
      i_half_period = $urandom_range(0, 6);
      i_step        = ($urandom % 2) ? $urandom : $signed($urandom_range(0, 64)) - 32;
      if ($urandom % 8 == 0) begin
        i_mod_amp_h = $urandom;
        i_mod_amp_l = $urandom;
      end
      tick();
    end

    // Reset during MOD_L with a nonzero accumulator
    i_en = 1; i_ramp_en = 1; i_ramp_sync = 0; i_half_period = 4;
    i_step = 32'h0123_4567;
    i_ramp_sync = 1; tick(); i_ramp_sync = 0;
    for (int n = 0; n < 20 && !(m_on && !m_level && m_pos == 2); n++) tick();
    chk("pre_rst_low", {30'd0, o_cstate}, 32'd2);
    #2;
    i_rst = 1;
    #1;
    model_reset();
    check_all();
    tick();
    i_rst = 0;
    tick();
    chk("restart_trig", {31'd0, o_trig}, 32'd1);
    chk("restart_status", {31'd0, o_status}, 32'd1);
    repeat (12) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
